// File: rtl/stream_pkg.sv
// Shared stream definitions: arbiter state encoding, default word width and
// the modular index helper used by the round-robin search.
package stream_pkg;

  localparam int unsigned STREAM_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // (base + off) mod n, used to walk the request ring.
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request found when
// searching upward from (rr_ptr_i + 1) with wrap-around.
module rr_pick
  import stream_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic                 hit_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W-1:0] cand;

  // Offset 1 is examined first, so the port just served ranks last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'(wrap_add(32'(rr_ptr_i), unsigned'(k), NUM_PORTS));
      if (!hit_o && req_i[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 stream arbiter: round-robin grant held for a burst of up to
// MAX_BURST words, single registered output stage, one-bubble turnaround.
module stream_rr_arbiter
  import stream_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  parameter  int unsigned DATA_W    = STREAM_DATA_W,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned IDX_W     = $clog2(NUM_PORTS),
  localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_PORTS*DATA_W-1:0] din,
  input  logic [NUM_PORTS-1:0]        val_in,
  output logic [NUM_PORTS-1:0]        ready_upward,
  output logic [DATA_W-1:0]           dout,
  output logic                        val_out,
  input  logic                        ready_downward,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        busy
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q;
  logic              val_out_q;

  logic              pick_hit;
  logic [IDX_W-1:0]  pick_idx;
  logic              slot_ready;
  logic              cur_valid;
  logic              accept;
  logic              last_beat;
  logic [DATA_W-1:0] din_arr [NUM_PORTS];

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_pick (
    .req_i    (val_in),
    .rr_ptr_i (rr_ptr_q),
    .hit_o    (pick_hit),
    .idx_o    (pick_idx)
  );

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      din_arr[p] = din[p*DATA_W +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and arbitration bookkeeping
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
          end
        end else if (slot_ready) begin
          // Slot offered but the owner had nothing: release the grant.
          state_d  = IDLE;
          rr_ptr_d = grant_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: only the granted port sees ready, and only when the
  // output register is empty or draining this cycle.
  always_comb begin
    busy                  = (state_q == GRANT);
    slot_ready            = busy & (~val_out_q | ready_downward);
    cur_valid             = val_in[grant_q];
    accept                = slot_ready & cur_valid;
    last_beat             = ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST));
    ready_upward          = '0;
    ready_upward[grant_q] = slot_ready;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_PORTS - 1);
      cnt_q    <= '0;
    end else begin
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output stage: load on accept, hold under back-pressure, empty on drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q    <= '0;
      val_out_q <= 1'b0;
    end else if (accept) begin
      dout_q    <= din_arr[grant_q];
      val_out_q <= 1'b1;
    end else if (ready_downward) begin
      val_out_q <= 1'b0;
    end
  end

  assign dout     = dout_q;
  assign val_out  = val_out_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: queued source models per port,
// expected word and grant queues drained by an independent monitor.
module tb_stream_rr_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;

  typedef logic [DW-1:0] word_t;
  typedef struct {
    int port;
    int len;
    int gap;
  } gexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [NP*DW-1:0] din;
  logic [NP-1:0]    val_in;
  logic             ready_downward;

  logic [NP-1:0] ru_a, ru_b;
  logic [DW-1:0] dout_a, dout_b;
  logic          vo_a, vo_b;
  logic [IW-1:0] gid_a, gid_b;
  logic          busy_a, busy_b;

  logic [NP-1:0] ready_upward;
  logic [DW-1:0] dout;
  logic          val_out;
  logic [IW-1:0] grant_id;
  logic          busy;

  bit sel16   = 1'b1;
  bit rdy_dn_v = 1'b1;

  word_t src_q [NP][$];
  word_t exp_q [$];
  gexp_t gexp_q [$];

  int checks   = 0;
  int failures = 0;

  stream_rr_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_BURST(4)) u_dut_b4 (
    .clk(clk), .resetn(resetn), .din(din), .val_in(val_in),
    .ready_upward(ru_a), .dout(dout_a), .val_out(vo_a),
    .ready_downward(ready_downward), .grant_id(gid_a), .busy(busy_a)
  );

  stream_rr_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_BURST(16)) u_dut_b16 (
    .clk(clk), .resetn(resetn), .din(din), .val_in(val_in),
    .ready_upward(ru_b), .dout(dout_b), .val_out(vo_b),
    .ready_downward(ready_downward), .grant_id(gid_b), .busy(busy_b)
  );

  always_comb begin
    ready_upward = sel16 ? ru_b   : ru_a;
    dout         = sel16 ? dout_b : dout_a;
    val_out      = sel16 ? vo_b   : vo_a;
    grant_id     = sel16 ? gid_b  : gid_a;
    busy         = sel16 ? busy_b : busy_a;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Source models: present queue head, pop on handshake at the coming edge.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      val_in[p]         = (src_q[p].size() != 0);
      din[p*DW +: DW]   = (src_q[p].size() != 0) ? src_q[p][0] : '0;
    end
    ready_downward = rdy_dn_v;
    #1;
    if (resetn) begin
      for (int p = 0; p < NP; p++) begin
        if (val_in[p] && ready_upward[p]) void'(src_q[p].pop_front());
      end
    end
  end

  // Monitor: output words, ready decode, grant order / length / bubble.
  bit            prev_busy = 1'b0;
  int            beat_cnt  = 0;
  int            gap_cnt   = 1000;
  always @(negedge clk) begin : monitor
    logic [NP-1:0] exp_ru;
    gexp_t         cur;
    #2;
    if (!resetn) begin
      if (prev_busy && gexp_q.size() != 0) void'(gexp_q.pop_front());
      prev_busy = 1'b0;
      beat_cnt  = 0;
      gap_cnt   = 1000;
    end else begin
      if (val_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(dout), 64'hDEAD_BEEF_0000_0000);
        end else begin
          check("dout", 64'(dout), 64'(exp_q[0]));
          if (ready_downward) void'(exp_q.pop_front());
        end
      end
      exp_ru = '0;
      if (busy && (!val_out || ready_downward)) exp_ru[grant_id] = 1'b1;
      check("ready_upward", 64'(ready_upward), 64'(exp_ru));
      if (busy && !prev_busy) begin
        beat_cnt = 0;
        if (gexp_q.size() == 0) begin
          check("unexpected_grant", 64'(grant_id), 64'hFF);
        end else begin
          cur = gexp_q[0];
          check("grant_port", 64'(grant_id), 64'(cur.port));
          if (cur.gap >= 0) check("bubble_cycles", 64'(gap_cnt), 64'(cur.gap));
        end
      end
      if (!busy && prev_busy) begin
        if (gexp_q.size() != 0) begin
          cur = gexp_q.pop_front();
          if (cur.len >= 0) check("burst_len", 64'(beat_cnt), 64'(cur.len));
        end
        gap_cnt = 1;
      end else if (!busy && gap_cnt < 1000) begin
        gap_cnt++;
      end
      if (busy && |(ready_upward & val_in)) beat_cnt++;
      prev_busy = busy;
    end
  end

  task automatic load_src(input int p, input int first, input int n);
    for (int i = 0; i < n; i++) src_q[p].push_back(DW'((p << 8) | (first + i)));
  endtask

  task automatic push_exp(input int p, input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DW'((p << 8) | (first + i)));
  endtask

  task automatic push_grant(input int p, input int len, input int gap);
    gexp_t g;
    g.port = p;
    g.len  = len;
    g.gap  = gap;
    gexp_q.push_back(g);
  endtask

  task automatic reset_on(input bit s16, input bit flush);
    resetn = 1'b0;
    sel16  = s16;
    if (flush) begin
      for (int p = 0; p < NP; p++) src_q[p].delete();
      exp_q.delete();
      gexp_q.delete();
    end
    #1;
    check("rst_val_out", 64'(val_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready_upward", 64'(ready_upward), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
  endtask

  task automatic reset_off();
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #3;
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
             (src_q[2].size() == 0) && (src_q[3].size() == 0) &&
             (exp_q.size() == 0) && (gexp_q.size() == 0) && !busy && !val_out;
    end
    check(nm, 64'(done), 64'd1);
  endtask

  // Directed timeline for a 3-word burst on port 2 (samples after each edge).
  bit    t1_busy [1:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit    t1_vo   [1:5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  word_t t1_dout [1:5] = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'h0};

  initial begin
    bit found;
    resetn = 1'b1;
    #2;

    // Port 2 alone, 3 words, downstream always ready.
    reset_on(1'b1, 1'b1);
    reset_off();
    src_q[2].push_back(32'hA0); src_q[2].push_back(32'hA1); src_q[2].push_back(32'hA2);
    exp_q.push_back(32'hA0);    exp_q.push_back(32'hA1);    exp_q.push_back(32'hA2);
    push_grant(2, 3, -1);
    @(negedge clk); #3;
    check("t1_n0_busy", 64'(busy), 64'd0);
    check("t1_n0_val_out", 64'(val_out), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #3;
      check("t1_busy", 64'(busy), 64'(t1_busy[k]));
      check("t1_val_out", 64'(val_out), 64'(t1_vo[k]));
      if (t1_vo[k]) check("t1_dout", 64'(dout), 64'(t1_dout[k]));
      if (t1_busy[k]) check("t1_grant_id", 64'(grant_id), 64'd2);
    end
    wait_idle("t1_drain", 50);

    // All ports valid, MAX_BURST 4: rotation 0,1,2,3,0 with single bubbles.
    reset_on(1'b0, 1'b1);
    load_src(0, 0, 8); load_src(1, 0, 4); load_src(2, 0, 4); load_src(3, 0, 4);
    push_exp(0, 0, 4); push_exp(1, 0, 4); push_exp(2, 0, 4); push_exp(3, 0, 4); push_exp(0, 4, 4);
    push_grant(0, 4, -1); push_grant(1, 4, 1); push_grant(2, 4, 1);
    push_grant(3, 4, 1);  push_grant(0, 4, 1);
    reset_off();
    wait_idle("t2_drain", 100);

    // Port 1 streaming with a 5-cycle downstream stall mid-burst.
    reset_on(1'b1, 1'b1);
    load_src(1, 0, 8);
    push_exp(1, 0, 8);
    push_grant(1, 8, -1);
    reset_off();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #3;
      found = (exp_q.size() <= 5);
    end
    check("t3_reach_stall", 64'(found), 64'd1);
    rdy_dn_v = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #3;
      check("t3_stall_busy", 64'(busy), 64'd1);
      check("t3_stall_ready1", 64'(ready_upward), 64'd0);
      check("t3_stall_val_out", 64'(val_out), 64'd1);
    end
    rdy_dn_v = 1'b1;
    wait_idle("t3_drain", 60);

    // Sole requester port 3, 40 words, MAX_BURST 16: bursts 16,16,8.
    reset_on(1'b1, 1'b1);
    load_src(3, 0, 40);
    push_exp(3, 0, 40);
    push_grant(3, 16, -1); push_grant(3, 16, 1); push_grant(3, 8, 1);
    reset_off();
    wait_idle("t4_drain", 200);

    // Port 1 alone, then ports 1 and 2 together: port 2 wins next.
    reset_on(1'b1, 1'b1);
    load_src(1, 0, 2);
    push_exp(1, 0, 2);
    push_grant(1, 2, -1);
    reset_off();
    wait_idle("t5a_drain", 50);
    load_src(1, 2, 2); load_src(2, 0, 2);
    push_exp(2, 0, 2); push_exp(1, 2, 2);
    push_grant(2, 2, -1); push_grant(1, 2, 1);
    wait_idle("t5b_drain", 50);

    // Reset while word 5 of a port-0 burst sits in the output register.
    reset_on(1'b1, 1'b1);
    load_src(0, 0, 10);
    push_exp(0, 0, 4);
    push_grant(0, -1, -1);
    reset_off();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #3;
      found = val_out && (dout == 32'h0000_0004);
    end
    check("t6_reach_word5", 64'(found), 64'd1);
    check("t6_words_before_reset", 64'(exp_q.size()), 64'd0);
    reset_on(1'b1, 1'b0);
    load_src(1, 0, 2);
    push_exp(0, 5, 5); push_exp(1, 0, 2);
    push_grant(0, 5, -1); push_grant(1, 2, 1);
    reset_off();
    wait_idle("t6_drain", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of upstream requester stream ports (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, stream word width.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum words per grant (1..256).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port din  input  NUM_PORTS*DATA_W  upstream data, port i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port val_in  input  NUM_PORTS  upstream valid, one bit per port.
REQ-008 SHALL have port ready_upward  output  NUM_PORTS  upstream ready, one bit per port.
REQ-009 SHALL have port dout  output  DATA_W  downstream data, registered.
REQ-010 SHALL have port val_out  output  1  downstream valid, registered.
REQ-011 SHALL have port ready_downward  input  1  downstream ready (fifo_stream ready_upward).
REQ-012 SHALL have port grant_id  output  clog2(NUM_PORTS)  index of current/last granted port.
REQ-013 SHALL have port busy  output  1  high while state is GRANT.

Function
REQ-014 SHALL transfer a beat on any port exactly when valid and ready are both high on a rising clk edge.
REQ-015 SHALL implement two states: IDLE, GRANT.
REQ-016 IDLE: SHALL select the first port with val_in high, searching round-robin from (rr_ptr+1) mod NUM_PORTS; on a hit, load grant_id, clear burst counter, go to GRANT; no upstream beat accepted in IDLE.
REQ-017 IDLE with no val_in high: SHALL stay in IDLE; grant_id and rr_ptr unchanged.
REQ-018 GRANT: ready_upward[grant_id] SHALL equal (!val_out | ready_downward); all other ready_upward bits SHALL be 0; in IDLE all bits SHALL be 0.
REQ-019 Accepted beat SHALL appear on dout with val_out high on the next cycle (1-cycle latency).
REQ-020 While val_out high and ready_downward low, dout and val_out SHALL hold stable.
REQ-021 When output register drains (ready_downward high) with no new beat accepted, val_out SHALL go low next cycle.
REQ-022 Burst counter SHALL increment per accepted beat; on the beat that makes count equal MAX_BURST, SHALL return to IDLE and set rr_ptr to grant_id.
REQ-023 In GRANT, if val_in[grant_id] is low while ready_upward[grant_id] is high, SHALL return to IDLE and set rr_ptr to grant_id (idle-release); a low val_in during downstream stall SHALL NOT release.
REQ-024 Re-arbitration after release SHALL cost exactly one IDLE cycle (one-bubble turnaround).
REQ-025 A sole active requester SHALL be re-granted after the bubble; with all ports continuously valid, grants SHALL rotate 0,1,2,...,NUM_PORTS-1,0.
REQ-026 Words from one burst SHALL never interleave with another port's words.
REQ-027 busy SHALL be 1 exactly in GRANT.

Reset
REQ-028 On resetn low, asynchronously: state IDLE, val_out 0, dout 0, ready_upward 0, busy 0, burst counter 0, grant_id 0, rr_ptr NUM_PORTS-1 (port 0 wins first).
REQ-029 Reset mid-burst SHALL discard any registered word; no beat SHALL be emitted until a new grant after resetn rises.
REQ-030 First arbitration SHALL occur on the first rising edge with resetn high.

Structure
REQ-031 Package stream_pkg SHALL hold the state enum (IDLE, GRANT) and default DATA_W constant, shared with fifo_stream users.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req vector, rr_ptr; outputs hit, index).
REQ-033 Burst counter width SHALL be clog2(MAX_BURST+1).

Verification
REQ-034 Reset then port 2 sends 3 words 0xA0..0xA2, downstream always ready -> grant_id 2, dout 0xA0,0xA1,0xA2 on consecutive cycles starting 2 cycles after val_in rises, then idle-release.
REQ-035 All 4 ports continuously valid, MAX_BURST 4 -> 4-word bursts in order port 0,1,2,3,0 with one bubble between bursts, no interleaving.
REQ-036 Port 1 streaming, ready_downward low 5 cycles mid-burst -> dout/val_out frozen, ready_upward[1] low, no release, no word lost or duplicated.
REQ-037 Only port 3 valid, 40 words, MAX_BURST 16 -> bursts of 16,16,8 all to port 3, one bubble between each.
REQ-038 resetn pulsed low during port 0 burst word 5 -> val_out 0 immediately, after release port 0 re-granted first (rr_ptr=3).
REQ-039 Ports 1 and 2 valid at once after port 1 burst released -> port 2 granted next.
